// File: rtl/ethernet_mac_encap.sv
// Transmit-side MAC framing: AXI-stream frame in, GMII bytes out with preamble/SFD,
// minimum-length padding, FCS and inter-frame gap; aborts with txer on underrun or oversize.
module ethernet_mac_encap #(
    parameter int unsigned MIN_PAYLOAD_LENGTH = 46,
    parameter int unsigned MAX_PAYLOAD_LENGTH = 1500,
    parameter int unsigned PREAMBLE_LENGTH    = 7,
    parameter int unsigned IFG_LENGTH         = 12
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tdata,
    input  logic       tvalid,
    output logic       tready,
    input  logic       tuser,
    input  logic       tlast,
    input  logic       clk_enable,
    output logic [7:0] gmii_txd,
    output logic       gmii_txen,
    output logic       gmii_txer,
    output logic       tx_busy,
    output logic       underrun
);
    localparam int unsigned MIN_FRAME_LENGTH = MIN_PAYLOAD_LENGTH + 14;
    localparam int unsigned MAX_FRAME_LENGTH = MAX_PAYLOAD_LENGTH + 14;
    localparam int unsigned CW   = $clog2(MAX_FRAME_LENGTH + 1);
    localparam int unsigned SMAX = (PREAMBLE_LENGTH > IFG_LENGTH) ? PREAMBLE_LENGTH : IFG_LENGTH;
    localparam int unsigned SW   = $clog2(((SMAX > 4) ? SMAX : 4) + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_SFD, S_DATA, S_PAD, S_FCS, S_DRAIN, S_IFG
    } state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   bcnt_q, bcnt_d, bcnt_inc;
    logic [31:0]     crc_q, crc_d;
    logic [7:0]      txd_q, txd_d;
    logic            txen_q, txen_d;
    logic            txer_q, txer_d;
    logic            underrun_q, underrun_d;

    // Reflected IEEE 802.3 CRC-32, one byte per call.
    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int unsigned i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    assign bcnt_inc  = bcnt_q + CW'(1);
    assign tready    = clk_enable & ((state_q == S_DATA) | (state_q == S_DRAIN));
    assign tx_busy   = (state_q != S_IDLE);
    assign gmii_txd  = txd_q;
    assign gmii_txen = txen_q;
    assign gmii_txer = txer_q;
    assign underrun  = underrun_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bcnt_d     = bcnt_q;
        crc_d      = crc_q;
        txd_d      = txd_q;
        txen_d     = txen_q;
        txer_d     = txer_q;
        underrun_d = 1'b0;
        if (clk_enable) begin
            txd_d  = '0;
            txen_d = 1'b0;
            txer_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (tvalid) begin
                        state_d = S_PREAMBLE;
                        cnt_d   = '0;
                    end
                end
                S_PREAMBLE: begin
                    txd_d  = 8'h55;
                    txen_d = 1'b1;
                    if (cnt_q == SW'(PREAMBLE_LENGTH - 1)) begin
                        state_d = S_SFD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + SW'(1);
                    end
                end
                S_SFD: begin
                    txd_d   = 8'hD5;
                    txen_d  = 1'b1;
                    crc_d   = '1;
                    bcnt_d  = '0;
                    state_d = S_DATA;
                end
                S_DATA: begin
                    txen_d = 1'b1;
                    cnt_d  = '0;
                    // A full-length frame without tlast is cut here; a beat offered in
                    // this cycle is swallowed, so a tlast on it ends the frame directly.
                    if (bcnt_q == CW'(MAX_FRAME_LENGTH)) begin
                        txer_d     = 1'b1;
                        underrun_d = 1'b1;
                        state_d    = (tvalid && tlast) ? S_IFG : S_DRAIN;
                    end else if (tvalid) begin
                        txd_d  = tdata;
                        txer_d = tuser;
                        crc_d  = crc_next(crc_q, tdata);
                        bcnt_d = bcnt_inc;
                        if (tlast) begin
                            state_d = (bcnt_inc < CW'(MIN_FRAME_LENGTH)) ? S_PAD : S_FCS;
                        end
                    end else begin
                        txer_d     = 1'b1;
                        underrun_d = 1'b1;
                        state_d    = S_DRAIN;
                    end
                end
                S_PAD: begin
                    txen_d = 1'b1;
                    crc_d  = crc_next(crc_q, 8'h00);
                    bcnt_d = bcnt_inc;
                    cnt_d  = '0;
                    if (bcnt_inc == CW'(MIN_FRAME_LENGTH)) begin
                        state_d = S_FCS;
                    end
                end
                S_FCS: begin
                    txen_d = 1'b1;
                    case (cnt_q[1:0])
                        2'd0:    txd_d = ~crc_q[7:0];
                        2'd1:    txd_d = ~crc_q[15:8];
                        2'd2:    txd_d = ~crc_q[23:16];
                        default: txd_d = ~crc_q[31:24];
                    endcase
                    if (cnt_q == SW'(3)) begin
                        state_d = S_IFG;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + SW'(1);
                    end
                end
                S_DRAIN: begin
                    cnt_d = '0;
                    if (tvalid && tlast) begin
                        state_d = S_IFG;
                    end
                end
                S_IFG: begin
                    if (cnt_q == SW'(IFG_LENGTH - 1)) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + SW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bcnt_q     <= '0;
            crc_q      <= '0;
            txd_q      <= '0;
            txen_q     <= 1'b0;
            txer_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bcnt_q     <= bcnt_d;
            crc_q      <= crc_d;
            txd_q      <= txd_d;
            txen_q     <= txen_d;
            txer_q     <= txer_d;
            underrun_q <= underrun_d;
        end
    end
endmodule
